// File: rtl/rr_mux_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_arbiter_if
//  Description : Bundle of the request/data/grant signals between four
//                requesters and the shared 3-bit channel arbiter.
//                  req[3:0]    request per requester (req[i] owns in<i>)
//                  in0..in3    3-bit requester data
//                  gnt[3:0]    one-hot grant, all-zero when idle
//                  sel[1:0]    channel select, index of current grantee
//                  out[2:0]    selected data, 3'b000 when not valid
//                  valid       a grant is active
//                master : requester side, slave : arbiter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface rr_mux_arbiter_if;
  logic [3:0] req;
  logic [2:0] in0;
  logic [2:0] in1;
  logic [2:0] in2;
  logic [2:0] in3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [2:0] out;
  logic       valid;

  modport master (
    output req, in0, in1, in2, in3,
    input  gnt, sel, out, valid
  );

  modport slave (
    input  req, in0, in1, in2, in3,
    output gnt, sel, out, valid
  );
endinterface
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_arbiter
//  Description : Round-robin arbiter sharing one 3-bit channel among four
//                requesters. A grant is held while its owner keeps
//                requesting, for at most HOLD_MAX consecutive cycles, then
//                passes to the next requester in rotation with no idle gap.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous active-high reset
//                bus    rr_mux_arbiter_if.slave (req, in0..in3 in;
//                       gnt, sel, out, valid out)
//  Parameters  : HOLD_MAX  maximum grant length in cycles (1..15)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_mux_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  rr_mux_arbiter_if.slave   bus
);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_grant = 1'b1;

  localparam logic [3:0] c_hold_max = 4'(HOLD_MAX);

  logic [0:0] r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic [3:0] r_hold_cnt;

  logic [1:0] w_arb_ptr;
  logic [1:0] w_idx;
  logic [1:0] w_win;
  logic       w_found;
  logic       w_keep;
  logic [2:0] w_out;

  // Arbitration start point. On a release the pointer moves past the current
  // owner in the same edge, so the search must already use sel+1; that also
  // puts the old owner last in line.
  always_comb begin
    w_arb_ptr = (r_state == c_st_grant) ? (r_sel + 2'd1) : r_ptr;
    w_idx     = '0;
    w_win     = w_arb_ptr;
    w_found   = 1'b0;
    // Walk from the lowest priority up so the highest-priority hit wins.
    for (int k = 3; k >= 0; k--) begin
      w_idx = w_arb_ptr + 2'(k);
      if (bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_keep = bus.req[r_sel] && (r_hold_cnt < c_hold_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_st_idle;
      r_gnt      <= 4'b0000;
      r_sel      <= 2'b00;
      r_ptr      <= 2'b00;
      r_hold_cnt <= 4'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_found) begin
            r_state    <= c_st_grant;
            r_gnt      <= 4'b0001 << w_win;
            r_sel      <= w_win;
            r_hold_cnt <= 4'd1;
          end
        end
        c_st_grant: begin
          if (w_keep) begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
          end else begin
            r_ptr <= r_sel + 2'd1;
            if (w_found) begin
              r_gnt      <= 4'b0001 << w_win;
              r_sel      <= w_win;
              r_hold_cnt <= 4'd1;
            end else begin
              // sel deliberately keeps its last value when going idle.
              r_state    <= c_st_idle;
              r_gnt      <= 4'b0000;
              r_hold_cnt <= 4'd0;
            end
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Channel data is not sampled: input changes during a grant pass through.
  always_comb begin
    w_out = 3'b000;
    if (|r_gnt) begin
      case (r_sel)
        2'd0:    w_out = bus.in0;
        2'd1:    w_out = bus.in1;
        2'd2:    w_out = bus.in2;
        default: w_out = bus.in3;
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.sel   = r_sel;
  assign bus.valid = |r_gnt;
  assign bus.out   = w_out;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_mux_arbiter
//  Description : Directed bench for rr_mux_arbiter. One instance uses
//                HOLD_MAX=4, a second uses HOLD_MAX=1; both see the same
//                request/data stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_mux_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [2:0] in0, in1, in2, in3;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter_if bus4 ();
  rr_mux_arbiter_if bus1 ();

  assign bus4.req = req;
  assign bus4.in0 = in0;
  assign bus4.in1 = in1;
  assign bus4.in2 = in2;
  assign bus4.in3 = in3;
  assign bus1.req = req;
  assign bus1.in0 = in0;
  assign bus1.in1 = in1;
  assign bus1.in2 = in2;
  assign bus1.in3 = in3;

  rr_mux_arbiter #(.HOLD_MAX(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
  rr_mux_arbiter #(.HOLD_MAX(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [2:0] in2;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [2:0] out;
    logic       valid;
  } vec_t;

  vec_t vecs[40];
  int   nv = 0;

  task automatic add(input logic [3:0] r, input logic [2:0] d2, input logic [3:0] g,
                     input logic [1:0] s, input logic [2:0] o, input logic v);
    vecs[nv].req   = r;
    vecs[nv].in2   = d2;
    vecs[nv].gnt   = g;
    vecs[nv].sel   = s;
    vecs[nv].out   = o;
    vecs[nv].valid = v;
    nv++;
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    in0   = 3'b001;
    in1   = 3'b010;
    in2   = 3'b101;
    in3   = 3'b110;

    // All four requesting: each owner holds exactly 4 cycles, rotation 0..3.
    for (int i = 0; i < 4; i++) add(4'b1111, 3'b101, 4'b0001, 2'd0, 3'b001, 1'b1);
    for (int i = 0; i < 4; i++) add(4'b1111, 3'b101, 4'b0010, 2'd1, 3'b010, 1'b1);
    for (int i = 0; i < 4; i++) add(4'b1111, 3'b101, 4'b0100, 2'd2, 3'b101, 1'b1);
    for (int i = 0; i < 4; i++) add(4'b1111, 3'b101, 4'b1000, 2'd3, 3'b110, 1'b1);
    add(4'b1111, 3'b101, 4'b0001, 2'd0, 3'b001, 1'b1);
    // Everyone drops: idle, ptr now 1.
    add(4'b0000, 3'b101, 4'b0000, 2'd0, 3'b000, 1'b0);
    // Grant on 1, keep one cycle, drop with req[3] waiting -> straight to 3.
    add(4'b0010, 3'b101, 4'b0010, 2'd1, 3'b010, 1'b1);
    add(4'b1010, 3'b101, 4'b0010, 2'd1, 3'b010, 1'b1);
    add(4'b1000, 3'b101, 4'b1000, 2'd3, 3'b110, 1'b1);
    // Owner 3 drops with nothing pending: idle, sel held, ptr wraps to 0.
    add(4'b0000, 3'b101, 4'b0000, 2'd3, 3'b000, 1'b0);
    add(4'b0011, 3'b101, 4'b0001, 2'd0, 3'b001, 1'b1);
    // Only requester 2: held 4 cycles, re-granted at the boundary, data passes through.
    add(4'b0100, 3'b101, 4'b0100, 2'd2, 3'b101, 1'b1);
    add(4'b0100, 3'b101, 4'b0100, 2'd2, 3'b101, 1'b1);
    add(4'b0100, 3'b011, 4'b0100, 2'd2, 3'b011, 1'b1);
    add(4'b0100, 3'b011, 4'b0100, 2'd2, 3'b011, 1'b1);
    add(4'b0100, 3'b101, 4'b0100, 2'd2, 3'b101, 1'b1);
    add(4'b0100, 3'b101, 4'b0100, 2'd2, 3'b101, 1'b1);
    // Idle: out forced to zero regardless of data.
    add(4'b0000, 3'b101, 4'b0000, 2'd2, 3'b000, 1'b0);
    add(4'b0000, 3'b111, 4'b0000, 2'd2, 3'b000, 1'b0);

    // Reset state, asserted at time zero.
    #2;
    chk("rst_gnt",   0, bus4.gnt, 4'b0000);
    chk("rst_sel",   0, {2'b00, bus4.sel}, 4'b0000);
    chk("rst_out",   0, {1'b0, bus4.out}, 4'b0000);
    chk("rst_valid", 0, {3'b000, bus4.valid}, 4'b0000);
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < nv; i++) begin
      req = vecs[i].req;
      in2 = vecs[i].in2;
      step();
      chk("vec_gnt",   i, bus4.gnt, vecs[i].gnt);
      chk("vec_sel",   i, {2'b00, bus4.sel}, {2'b00, vecs[i].sel});
      chk("vec_out",   i, {1'b0, bus4.out}, {1'b0, vecs[i].out});
      chk("vec_valid", i, {3'b000, bus4.valid}, {3'b000, vecs[i].valid});
    end

    // Idle with ptr=3: all requesting grants 3 first.
    in2 = 3'b101;
    req = 4'b1111;
    step();
    chk("pre_rst_gnt", 0, bus4.gnt, 4'b1000);

    // Asynchronous reset mid-cycle aborts the grant before any edge.
    #2;
    reset = 1'b1;
    #1;
    chk("async_gnt",   0, bus4.gnt, 4'b0000);
    chk("async_valid", 0, {3'b000, bus4.valid}, 4'b0000);
    chk("async_out",   0, {1'b0, bus4.out}, 4'b0000);
    step();
    step();
    reset = 1'b0;
    step();
    chk("post_rst_gnt", 0, bus4.gnt, 4'b0001);
    chk("post_rst_sel", 0, {2'b00, bus4.sel}, 4'b0000);

    // HOLD_MAX=1: pure per-cycle alternation between requesters 1 and 3.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) in3 = 3'b011;
      step();
      if (i % 2 == 0) begin
        chk("hm1_gnt", i, bus1.gnt, 4'b0010);
        chk("hm1_out", i, {1'b0, bus1.out}, {1'b0, in1});
      end else begin
        chk("hm1_gnt", i, bus1.gnt, 4'b1000);
        chk("hm1_out", i, {1'b0, bus1.out}, {1'b0, in3});
      end
      chk("hm1_valid", i, {3'b000, bus1.valid}, 4'b0001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one 3-bit output channel among four requesters. It produces the 2-bit select for the channel's 4:1 multiplexer, plus a one-hot grant back to the requesters. A grant is held while the owner keeps requesting, up to `HOLD_MAX` cycles, then passes to the next requester in rotation. The block sits between the requester logic and the 4:1 3-bit channel mux; the selected data is presented on `out` with a `valid` qualifier.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive cycles a single grant lasts. Legal range 1..15.
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `req`  input  4  request per requester; `req[i]` belongs to `in<i>`
- `in0`, `in1`, `in2`, `in3`  input  3 each  requester data
- `gnt`  output  4  one-hot grant, registered; all-zero when idle
- `sel`  output  2  registered channel select, index of the current grantee
- `out`  output  3  `in[sel]` when `valid`, else 3'b000 (combinational from the registered `sel`/`valid`)
- `valid`  output  1  high when a grant is active (`|gnt`)

## Operation
- Internal registers:
  - `state`: IDLE or GRANT.
  - `ptr[1:0]`: highest-priority index for the next arbitration.
  - `hold_cnt[3:0]`: cycles the current grant has lasted.
- Arbitration function: scan `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4) and pick the first index with `req` high.
- IDLE:
  - `gnt`=0, `valid`=0.
  - At an edge with `req!=0`: arbitrate, load `gnt`/`sel` with the winner, set `hold_cnt`=1, go to GRANT.
  - At an edge with `req==0`: stay in IDLE.
- GRANT, evaluated each edge:
  - **Keep:** if `req[sel]`=1 and `hold_cnt<HOLD_MAX`, increment `hold_cnt`. `gnt`/`sel` are unchanged.
  - **Release:** otherwise (owner dropped `req`, or `hold_cnt==HOLD_MAX`):
    - `ptr` <= `sel`+1 (mod 4).
    - Arbitrate in the same edge, starting from the new `ptr`. The old owner is eligible again only if still requesting, at lowest priority.
    - Winner found: load `gnt`/`sel`, `hold_cnt`=1, stay in GRANT. There is no idle gap between owners.
    - No request: go to IDLE with `gnt`=0; `sel` keeps its last value.
- `ptr` updates only on release. A fresh grant from IDLE uses the current `ptr`.
- `HOLD_MAX`=1 re-arbitrates every cycle, giving a pure per-cycle round-robin.
- Requests that arrive mid-grant are never lost. They are only served once the current grant releases.
- Changes on `in0..in3` during a grant pass straight to `out` (no sampling).

## Timing
- Reset values (asserted asynchronously, immediately): `state`=IDLE, `gnt`=4'b0000, `sel`=2'b00, `ptr`=2'b00, `hold_cnt`=0, `valid`=0, `out`=3'b000.
- Reset release: the first arbitration happens at the first rising edge with `reset` low.
- Request-to-grant latency: 1 clock edge from IDLE. `req` sampled high at edge N gives `gnt`/`valid` high after edge N.
- Owner drop: the deasserted `req` is seen at the next edge; `gnt` changes or clears after that edge.
- Maximum wait for a continuously requesting line: 3×`HOLD_MAX` cycles after the current grant starts.
- Reset during GRANT aborts the grant immediately. `ptr` returns to 0, so requester 0 has top priority after reset.

## Test plan
1. Assert `reset` while holding a grant, mid-cycle → `gnt`=0000, `valid`=0, `out`=000 immediately without a clock edge. After release with `req`=1111, the first grant is `gnt`=0001.
2. Only `req[2]`=1, `in2`=3'b101 →
   - One edge later: `gnt`=0100, `sel`=2, `out`=101, `valid`=1.
   - At the `HOLD_MAX` boundary requester 2 is re-granted (`hold_cnt` restarts at 1); `valid` never drops.
3. `req`=1111 held, `HOLD_MAX`=4 → `gnt` sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles, no gaps.
4. Grant on requester 1. Drop `req[1]` at hold cycle 2 while `req[3]`=1 → next edge `gnt`=1000, `sel`=3, `valid` continuously high.
5. Grant on requester 3. Drop `req[3]` with `req`=0000 → next edge `gnt`=0000, `valid`=0, `out`=000. A later `req`=0011 grants requester 0, since `ptr` wrapped to 0.
6. `HOLD_MAX`=1, `req`=1010 → `gnt` alternates 0010, 1000 every cycle; `out` tracks `in1`/`in3` accordingly.
